// File: rtl/rmt_parse_pkg.sv
// Shared parse/deparse definitions: container type codes, action field layout
// and PHV container placement.
package rmt_parse_pkg;

    localparam int unsigned META_WIDTH = 256;

    localparam int unsigned ACT_VALID_BIT = 0;
    localparam int unsigned ACT_IDX_LSB   = 1;
    localparam int unsigned ACT_IDX_W     = 3;
    localparam int unsigned ACT_TYPE_LSB  = 4;
    localparam int unsigned ACT_TYPE_W    = 2;
    localparam int unsigned ACT_OFF_LSB   = 6;
    localparam int unsigned ACT_OFF_W     = 7;
    // Bits above the offset field are reserved and never decoded.
    localparam int unsigned ACT_USED_W    = ACT_OFF_LSB + ACT_OFF_W;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_2B   = 2'b01,
        TYPE_4B   = 2'b10,
        TYPE_6B   = 2'b11
    } cont_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARSE  = 2'd1,
        ST_OUTPUT = 2'd2
    } parse_state_e;

    localparam int unsigned PHV_2B_START_POS = META_WIDTH;

    function automatic int unsigned phv_4b_start_pos(input int unsigned num_per_type);
        return META_WIDTH + 16 * num_per_type;
    endfunction

    function automatic int unsigned phv_6b_start_pos(input int unsigned num_per_type);
        return META_WIDTH + 48 * num_per_type;
    endfunction

    function automatic int unsigned type_bytes(input logic [1:0] t);
        case (cont_type_e'(t))
            TYPE_2B: return 2;
            TYPE_4B: return 4;
            TYPE_6B: return 6;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/phv_slot_extract.sv
// Combinational header slicer: returns the 2/4/6-byte slice at a byte offset,
// zero-extended to 48 bits, and whether the slice lies inside the window.
module phv_slot_extract
    import rmt_parse_pkg::*;
#(
    parameter int unsigned HDR_W = 1024
) (
    input  logic [HDR_W-1:0]      hdr_i,
    input  logic [ACT_OFF_W-1:0]  off_i,
    input  logic [ACT_TYPE_W-1:0] typ_i,
    output logic [47:0]           val_o,
    output logic                  in_range_o
);

    int unsigned size_bytes;
    logic [47:0] raw;

    always_comb begin
        size_bytes = type_bytes(typ_i);
        raw        = 48'(hdr_i >> {off_i, 3'b000});
        case (cont_type_e'(typ_i))
            TYPE_2B: val_o = {32'd0, raw[15:0]};
            TYPE_4B: val_o = {16'd0, raw[31:0]};
            TYPE_6B: val_o = raw;
            default: val_o = '0;
        endcase
        in_range_o = (typ_i != TYPE_NONE) && ((32'(off_i) + size_bytes) <= (HDR_W / 8));
    end

endmodule

// File: rtl/phv_field_parser.sv
// Header-to-PHV extractor: walks one parse action per cycle into PHV containers.
// Optional PARSER_ERR_CNT_EN adds a saturating err_cnt of skipped valid actions.
module phv_field_parser
    import rmt_parse_pkg::*;
#(
    parameter int unsigned NUM_PER_TYPE     = 8,
    parameter int unsigned C_PKT_VEC_WIDTH  = (6+4+2)*8*NUM_PER_TYPE+256,
    parameter int unsigned C_HDR_WIDTH      = 1024,
    parameter int unsigned C_PARSE_ACT_LEN  = 16,
    parameter int unsigned C_NUM_PARSE_ACTS = 10
) (
    input  logic                                        clk,
    input  logic                                        areset,
    input  logic                                        hdr_valid,
    output logic                                        hdr_ready,
    input  logic [C_HDR_WIDTH-1:0]                      hdr_data,
    input  logic [C_NUM_PARSE_ACTS*C_PARSE_ACT_LEN-1:0] parse_acts,
    input  logic [255:0]                                meta_in,
    output logic                                        phv_valid,
    input  logic                                        phv_ready,
    output logic [C_PKT_VEC_WIDTH-1:0]                  phv_out
`ifdef PARSER_ERR_CNT_EN
    ,
    output logic [15:0]                                 err_cnt
`endif
);

    localparam int unsigned ACTS_W = C_NUM_PARSE_ACTS * C_PARSE_ACT_LEN;
    localparam int unsigned IDX_W  = $clog2(C_NUM_PARSE_ACTS + 1);
    localparam int unsigned POS_4B = phv_4b_start_pos(NUM_PER_TYPE);
    localparam int unsigned POS_6B = phv_6b_start_pos(NUM_PER_TYPE);

    parse_state_e                 state_q;
    logic                         hdr_ready_q;
    logic                         phv_valid_q;
    logic [C_PKT_VEC_WIDTH-1:0]   phv_q;
    logic [C_PKT_VEC_WIDTH-1:0]   phv_d;
    logic [C_HDR_WIDTH-1:0]       hdr_q;
    logic [ACTS_W-1:0]            acts_q;
    logic [IDX_W-1:0]             act_idx_q;

    logic                         acts_done;
    logic [IDX_W-1:0]             act_sel;
    logic [ACT_USED_W-1:0]        act_word;
    logic                         act_valid;
    logic [ACT_IDX_W-1:0]         cur_idx;
    logic [ACT_TYPE_W-1:0]        cur_type;
    logic [ACT_OFF_W-1:0]         cur_off;
    logic [47:0]                  slot_val;
    logic                         slot_in_range;

    // act_idx runs one past the last action so the full list costs one extra
    // PARSE cycle, matching the early-termination latency of i+1.
    assign acts_done = (act_idx_q == IDX_W'(C_NUM_PARSE_ACTS));
    assign act_sel   = acts_done ? '0 : act_idx_q;
    assign act_word  = ACT_USED_W'(acts_q >> (act_sel * C_PARSE_ACT_LEN));
    assign act_valid = act_word[ACT_VALID_BIT];
    assign cur_idx   = act_word[ACT_IDX_LSB +: ACT_IDX_W];
    assign cur_type  = act_word[ACT_TYPE_LSB +: ACT_TYPE_W];
    assign cur_off   = act_word[ACT_OFF_LSB +: ACT_OFF_W];

    phv_slot_extract #(.HDR_W(C_HDR_WIDTH)) u_slot_extract (
        .hdr_i      (hdr_q),
        .off_i      (cur_off),
        .typ_i      (cur_type),
        .val_o      (slot_val),
        .in_range_o (slot_in_range)
    );

    always_comb begin
        phv_d = phv_q;
        if (act_valid && slot_in_range) begin
            case (cont_type_e'(cur_type))
                TYPE_2B: phv_d[PHV_2B_START_POS + 16*cur_idx +: 16] = slot_val[15:0];
                TYPE_4B: phv_d[POS_4B + 32*cur_idx +: 32]           = slot_val[31:0];
                TYPE_6B: phv_d[POS_6B + 48*cur_idx +: 48]           = slot_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            hdr_ready_q <= 1'b0;
            phv_valid_q <= 1'b0;
            phv_q       <= '0;
            act_idx_q   <= '0;
            hdr_q       <= '0;
            acts_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_valid && hdr_ready_q) begin
                        hdr_q       <= hdr_data;
                        acts_q      <= parse_acts;
                        phv_q       <= C_PKT_VEC_WIDTH'(meta_in);
                        act_idx_q   <= '0;
                        hdr_ready_q <= 1'b0;
                        state_q     <= ST_PARSE;
                    end else begin
                        hdr_ready_q <= 1'b1;
                    end
                end
                ST_PARSE: begin
                    if (acts_done || !act_valid) begin
                        phv_valid_q <= 1'b1;
                        state_q     <= ST_OUTPUT;
                    end else begin
                        phv_q     <= phv_d;
                        act_idx_q <= act_idx_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (phv_ready) begin
                        phv_valid_q <= 1'b0;
                        hdr_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hdr_ready = hdr_ready_q;
    assign phv_valid = phv_valid_q;
    assign phv_out   = phv_q;

`ifdef PARSER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_cnt_q <= '0;
        end else if (state_q == ST_PARSE && !acts_done && act_valid && !slot_in_range
                     && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
